gray_conv_pipe: RTL
===================

# gray_conv_pipe

Runtime-configurable, multi-lane Gray/binary code converter with a pipelined valid/ready datapath. It generalises the single-order gray2bin demapper: it converts in both directions, handles any modulation order up to a parametrised maximum on a per-beat basis, processes several symbols per beat and tolerates downstream backpressure. It sits between the soft/hard demapper (or bit source) and the bit (de)interleaver in the modem datapath.

## Interface

- MAX_MODULATION_ORDER, 256, largest supported constellation size; W = $clog2(MAX_MODULATION_ORDER) bits per symbol lane.
- LANES, 4, symbols carried per beat.
- PIPE_STAGES, 2, register stages from input to output; legal range 1..4.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_mode  in  1  0 = Gray→binary, 1 = binary→Gray; sampled with each accepted beat.
- i_bits_per_sym  in  $clog2(W+1)  active bits per symbol k; legal range 1..W; sampled with each accepted beat.
- i_data  in  LANES*W  input symbols; lane n occupies bits [n*W +: W].
- i_dv  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- o_data  out  LANES*W  converted symbols, same lane layout.
- o_dv  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_err  out  1  sticky flag: an illegal k has been seen.
- o_beat_count  out  32  number of output beats accepted downstream.

## Operation

- Input transfer when i_dv && o_ready; output transfer when o_dv && i_ready.
- Each beat carries its own mode and k through the pipeline; consecutive beats may differ.
- Per lane, only bits [k-1:0] are used. Input bits [W-1:k] are ignored; output bits [W-1:k] are driven 0.
- Gray→binary: b[k-1] = g[k-1]; b[i] = b[i+1] ^ g[i] for i = k-2 down to 0.
- Binary→Gray: g[i] = b[i] ^ b[i+1] for i < k-1; g[k-1] = b[k-1].
- Illegal k (0 or > W): the beat still passes through with all lanes 0, and o_err is set. o_err clears only on rst.
- Conversion logic may be placed in any stage(s). Only latency and ordering are observable.
- Pipeline: PIPE_STAGES valid-tagged stages. A stage loads when it is empty or when its contents move on in the same cycle, so bubbles collapse.
- o_ready = stage 1 empty, or stage 1 advancing this cycle (combinational from i_ready through the chain; no combinational path from i_dv).
- o_beat_count increments on every output transfer and wraps from 2^32-1 to 0.

## Timing

- Reset values: o_dv = 0, o_data = 0, o_err = 0, o_beat_count = 0, all stage valids 0. o_ready = 1 once rst is low.
- Reset acts asynchronously at any time, including mid-stream: in-flight beats are discarded and nothing is replayed.
- Latency: a beat accepted at cycle t appears on o_dv/o_data at cycle t+PIPE_STAGES if there is no stall.
- Throughput: one beat per cycle while i_ready = 1.
- Stall: while o_dv && !i_ready, o_data and o_dv hold stable. At most PIPE_STAGES beats are buffered, after which o_ready drops.
- A transfer on the same cycle that i_ready rises is legal; no beat is lost or duplicated, and order is preserved.
- o_err rises on the cycle the illegal beat is accepted at the input.

## Structure

- Package gray_conv_pkg: mode enum (GRAY2BIN, BIN2GRAY); a stage struct {valid, mode, k, data}; pure functions gray2bin_f(x, k) and bin2gray_f(x, k).
- One sub-module, gray_conv_lane: combinational single-lane converter, instantiated LANES times.
- Top module: pipeline registers, handshake logic, error flag and counter.

## Test plan

Defaults: MAX_MODULATION_ORDER = 256, LANES = 4, PIPE_STAGES = 2.

- Gray→binary, k = 4, all lanes 0x0D → all lanes 0x09, o_dv two cycles after acceptance.
- Binary→Gray, k = 8, lanes 0xFF/0x00/0x01/0x80 → 0x80/0x00/0x01/0xC0.
- Gray→binary, k = 2, lane 0xF6 → 0x03 (upper input bits ignored); next beat binary→Gray k = 8 0x02 → 0x03, showing per-beat mode switching.
- Continuous 20-beat ramp with i_ready low for cycles 5–9 → o_ready drops after 2 buffered beats, all 20 beats arrive in order with none lost or duplicated, o_beat_count = 20.
- k = 0 beat, then k = 9 beat → both outputs 0, o_err = 1 and stays high through later legal beats until rst.
- Assert rst mid-stream with 2 beats in flight → o_dv, o_err and o_beat_count are 0 immediately; beats accepted after release convert correctly.

Source files
------------

// File: rtl/gray_conv_pkg.sv
// Shared types and conversion helpers for the Gray/binary lane converter.
// Symbols are right-aligned: only bits [k-1:0] carry information.
package gray_conv_pkg;

    localparam int MAX_MOD_ORDER = 256;
    localparam int NLANES        = 4;
    localparam int W             = $clog2(MAX_MOD_ORDER);
    localparam int KW            = $clog2(W + 1);

    typedef enum logic {
        GRAY2BIN = 1'b0,
        BIN2GRAY = 1'b1
    } mode_e;

    typedef logic [W-1:0]  sym_t;
    typedef logic [KW-1:0] k_t;

    typedef struct packed {
        logic                  valid;
        mode_e                 mode;
        k_t                    k;
        logic [NLANES*W-1:0]   data;
    } stage_t;

    function automatic logic k_legal_f(k_t k);
        return (k != '0) && (int'(k) <= W);
    endfunction

    // Running XOR from the MSB down to bit 0, restricted to the active k bits.
    function automatic sym_t gray2bin_f(sym_t x, k_t k);
        sym_t b;
        logic acc;
        b   = '0;
        acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i < int'(k)) begin
                acc  = acc ^ x[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

    function automatic sym_t bin2gray_f(sym_t x, k_t k);
        sym_t g;
        sym_t hi;
        g  = '0;
        hi = x >> 1;
        for (int i = 0; i < W; i++) begin
            if (i < int'(k)) begin
                g[i] = x[i] ^ ((i + 1 < int'(k)) ? hi[i] : 1'b0);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/gray_conv_pipe_if.sv
// Valid/ready beat interface of the Gray/binary converter.
// The master drives beats in and accepts results; the slave is the converter.
interface gray_conv_pipe_if #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int KW    = $clog2(W + 1)
);

    logic                 i_mode;
    logic [KW-1:0]        i_bits_per_sym;
    logic [LANES*W-1:0]   i_data;
    logic                 i_dv;
    logic                 o_ready;
    logic [LANES*W-1:0]   o_data;
    logic                 o_dv;
    logic                 i_ready;
    logic                 o_err;
    logic [31:0]          o_beat_count;

    modport master (
        output i_mode,
        output i_bits_per_sym,
        output i_data,
        output i_dv,
        output i_ready,
        input  o_ready,
        input  o_data,
        input  o_dv,
        input  o_err,
        input  o_beat_count
    );

    modport slave (
        input  i_mode,
        input  i_bits_per_sym,
        input  i_data,
        input  i_dv,
        input  i_ready,
        output o_ready,
        output o_data,
        output o_dv,
        output o_err,
        output o_beat_count
    );

endinterface

// File: rtl/gray_conv_lane.sv
// Combinational single-symbol Gray<->binary converter.
// An illegal k yields an all-zero symbol.
module gray_conv_lane
    import gray_conv_pkg::*;
(
    input  mode_e i_mode,
    input  k_t    i_k,
    input  sym_t  i_sym,
    output sym_t  o_sym
);

    always_comb begin
        o_sym = '0;
        if (k_legal_f(i_k)) begin
            if (i_mode == BIN2GRAY) begin
                o_sym = bin2gray_f(i_sym, i_k);
            end else begin
                o_sym = gray2bin_f(i_sym, i_k);
            end
        end
    end

endmodule

// File: rtl/gray_conv_pipe.sv
// Multi-lane Gray/binary converter behind a collapsing valid/ready pipeline.
// Raw beats travel with their mode and k; conversion happens at the last stage.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int MAX_MODULATION_ORDER = MAX_MOD_ORDER,
    parameter int LANES                = NLANES,
    parameter int PIPE_STAGES          = 2
) (
    input  logic             clk,
    input  logic             rst,
    gray_conv_pipe_if.slave  bus
);

    localparam int LW = $clog2(MAX_MODULATION_ORDER);

    stage_t                 r_stg [PIPE_STAGES];
    logic                   r_err;
    logic [31:0]            r_cnt;
    logic [PIPE_STAGES-1:0] w_en;
    logic                   w_acc;
    logic [LANES*LW-1:0]    w_conv;
    logic                   w_out_xfer;

    // A stage may load if it or any stage after it has room.
    always_comb begin
        w_acc = bus.i_ready;
        w_en  = '0;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            w_acc   = w_acc | ~r_stg[s].valid;
            w_en[s] = w_acc;
        end
    end

    assign w_out_xfer = r_stg[PIPE_STAGES-1].valid & bus.i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_stg[s] <= '0;
            end
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_en[0]) begin
                r_stg[0] <= '{
                    valid: bus.i_dv,
                    mode:  mode_e'(bus.i_mode),
                    k:     bus.i_bits_per_sym,
                    data:  bus.i_data
                };
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (w_en[s]) begin
                    r_stg[s] <= r_stg[s-1];
                end
            end
            if (bus.i_dv && w_en[0]
                && !k_legal_f(bus.i_bits_per_sym)) begin
                r_err <= 1'b1;
            end
            if (w_out_xfer) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        gray_conv_lane u_lane (
            .i_mode (r_stg[PIPE_STAGES-1].mode),
            .i_k    (r_stg[PIPE_STAGES-1].k),
            .i_sym  (r_stg[PIPE_STAGES-1].data[n*LW +: LW]),
            .o_sym  (w_conv[n*LW +: LW])
        );
    end

    assign bus.o_ready      = w_en[0];
    assign bus.o_dv         = r_stg[PIPE_STAGES-1].valid;
    assign bus.o_data       = r_stg[PIPE_STAGES-1].valid ? w_conv : '0;
    assign bus.o_err        = r_err;
    assign bus.o_beat_count = r_cnt;

endmodule
